// File: rtl/control_unit_pipe.sv
// ---------------------------------------------------------------------------
// control_unit_pipe
//
// Decode-to-execute control unit. It decodes opcode and funct7 into datapath
// control signals and registers them into the EX stage, so an instruction
// accepted at one clock edge appears on the outputs right after that edge.
// A multiply (R-type opcode with funct7 = 0000001) takes MUL_LATENCY cycles.
// The unit holds off upstream with a combinational stall while the multiply
// runs. A bubble is inserted on flush, when no valid instruction is present,
// and for unknown opcodes.
//
// Optional feature macro: CU_ILLEGAL_TRAP_EN
//   When defined, the registered output illegal_op pulses for one cycle. The
//   pulse lines up with the bubble produced by an accepted unknown opcode.
//   When undefined, that port does not exist.
//
// Parameters
//   MUL_LATENCY  multiply latency in cycles (1..16); 1 = single cycle, no stall
//   CNT_W        multiply counter width; must hold MUL_LATENCY-1
//
// Ports
//   clk        in   rising-edge clock
//   arst_n     in   asynchronous active-low reset
//   valid_in   in   opcode/funct7 carry a valid instruction this cycle
//   opcode     in   instr[6:0]
//   funct7     in   instr[31:25]
//   flush      in   kill the in-flight instruction (taken branch or jump)
//   stall      out  combinational; upstream holds its instruction while 1
//   valid_out  out  EX-stage control word is valid
//   alu_op     out  00 add, 01 sub, 10 R-type, 11 mult
//   alu_src, mem_2_reg, reg_write, mem_read, mem_write, branch, jump  out
//   illegal_op out  (CU_ILLEGAL_TRAP_EN only) unknown-opcode pulse
//   state_dbg  out  FSM state (0 = IDLE, 1 = MUL)
//   cnt_dbg    out  multiply cycle counter
//
// Handshake: the unit accepts an instruction at a clock edge when
// valid_in & ~stall & ~flush is true at that edge. While stall is 1,
// upstream must keep presenting the same instruction. valid_out marks a
// complete control word; there is no back-pressure from EX.
// ---------------------------------------------------------------------------
module control_unit_pipe #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             valid_in,
  input  logic [6:0]       opcode,
  input  logic [6:0]       funct7,
  input  logic             flush,
  output logic             stall,
  output logic             valid_out,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             mem_2_reg,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch,
  output logic             jump,
`ifdef CU_ILLEGAL_TRAP_EN
  output logic             illegal_op,
`endif
  output logic             state_dbg,
  output logic [CNT_W-1:0] cnt_dbg
);

  // FSM states
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  // Opcodes
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] F7_MUL   = 7'b0000001;

  // Control vector bit order: alu_src, mem_2_reg, reg_write, mem_read,
  // mem_write, branch, jump (MSB first).
  localparam int         RW_BIT   = 4;
  localparam logic [6:0] RW_MASK  = 7'b0010000;

  // A 1-cycle multiply never enters the MUL state.
  localparam logic             MULTI_CYCLE = (MUL_LATENCY > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // -------------------------------------------------------------------------
  // Decode (combinational)
  // -------------------------------------------------------------------------
  logic       dec_known;
  logic       dec_mul;
  logic [6:0] dec_ctrl;
  logic [1:0] dec_alu;

  always_comb begin
    dec_known = 1'b1;
    dec_mul   = 1'b0;
    dec_ctrl  = 7'b0000000;
    dec_alu   = 2'b00;
    case (opcode)
      OP_R: begin
        dec_ctrl = 7'b0010000;
        if (funct7 == F7_MUL) begin
          dec_alu = 2'b11;
          dec_mul = 1'b1;
        end else begin
          dec_alu = 2'b10;
        end
      end
      OP_I:     dec_ctrl = 7'b1010000;
      OP_LOAD:  dec_ctrl = 7'b1111000;
      OP_STORE: dec_ctrl = 7'b1000100;
      OP_BEQ: begin
        dec_ctrl = 7'b0000010;
        dec_alu  = 2'b01;
      end
      OP_JAL: begin
        dec_ctrl = 7'b0000001;
        dec_alu  = 2'b10;
      end
      default:  dec_known = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, counter and EX-stage registers
  // -------------------------------------------------------------------------
  logic [0:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [6:0]       ctrl_q;
  logic [1:0]       alu_q;
  logic             valid_q;
  logic             illegal_q;
  logic             accept;

  // Flush overrides the stall so upstream can redirect at once.
  assign stall  = (state_q == S_MUL) & ~flush;
  assign accept = valid_in & ~stall & ~flush;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      alu_q     <= 2'b00;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      // Kill everything in flight, including a multiply before its write.
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      alu_q     <= 2'b00;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (state_q == S_MUL) begin
      // Inputs are ignored here; the MUL word stays registered with
      // reg_write low until the final cycle.
      illegal_q <= 1'b0;
      if (cnt_q == CNT_ONE) begin
        state_q        <= S_IDLE;
        cnt_q          <= '0;
        ctrl_q[RW_BIT] <= 1'b1;
        valid_q        <= 1'b1;
      end else begin
        cnt_q <= cnt_q - CNT_ONE;
      end
    end else begin
      illegal_q <= 1'b0;
      if (accept && dec_known) begin
        alu_q <= dec_alu;
        if (dec_mul && MULTI_CYCLE) begin
          state_q <= S_MUL;
          cnt_q   <= CNT_LOAD;
          ctrl_q  <= dec_ctrl & ~RW_MASK;
          valid_q <= 1'b0;
        end else begin
          ctrl_q  <= dec_ctrl;
          valid_q <= 1'b1;
        end
      end else begin
        // Bubble: no instruction, or an unknown opcode.
        ctrl_q    <= '0;
        alu_q     <= 2'b00;
        valid_q   <= 1'b0;
        illegal_q <= accept & ~dec_known;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign alu_src   = ctrl_q[6];
  assign mem_2_reg = ctrl_q[5];
  assign reg_write = ctrl_q[4];
  assign mem_read  = ctrl_q[3];
  assign mem_write = ctrl_q[2];
  assign branch    = ctrl_q[1];
  assign jump      = ctrl_q[0];
  assign alu_op    = alu_q;
  assign valid_out = valid_q;
  assign state_dbg = state_q[0];
  assign cnt_dbg   = cnt_q;

`ifdef CU_ILLEGAL_TRAP_EN
  assign illegal_op = illegal_q;
`else
  // Without the trap port the flag has no reader.
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_control_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_control_unit_pipe
//
// Directed bench for control_unit_pipe. u_dut uses MUL_LATENCY=4 and
// u_dut1 uses MUL_LATENCY=1. Outputs are packed as
// {valid_out, alu_op, alu_src, mem_2_reg, reg_write, mem_read, mem_write,
// branch, jump} and compared with hand-computed words.
// ---------------------------------------------------------------------------
module tb_control_unit_pipe;

  // Clock / reset
  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  // u_dut (MUL_LATENCY = 4)
  logic       valid_in, flush;
  logic [6:0] opcode, funct7;
  logic       stall, valid_out, alu_src, mem_2_reg, reg_write;
  logic       mem_read, mem_write, branch, jump, state_dbg;
  logic [1:0] alu_op;
  logic [3:0] cnt_dbg;
`ifdef CU_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  // u_dut1 (MUL_LATENCY = 1)
  logic       valid_in1, flush1;
  logic [6:0] opcode1, funct71;
  logic       stall1, valid_out1, alu_src1, mem_2_reg1, reg_write1;
  logic       mem_read1, mem_write1, branch1, jump1, state_dbg1;
  logic [1:0] alu_op1;
  logic [3:0] cnt_dbg1;
`ifdef CU_ILLEGAL_TRAP_EN
  logic       illegal_op1;
`endif

  logic [9:0] word, word1;
  assign word  = {valid_out, alu_op, alu_src, mem_2_reg, reg_write,
                  mem_read, mem_write, branch, jump};
  assign word1 = {valid_out1, alu_op1, alu_src1, mem_2_reg1, reg_write1,
                  mem_read1, mem_write1, branch1, jump1};

  control_unit_pipe #(.MUL_LATENCY(4), .CNT_W(4)) u_dut (
    .clk(clk), .arst_n(arst_n), .valid_in(valid_in), .opcode(opcode),
    .funct7(funct7), .flush(flush), .stall(stall), .valid_out(valid_out),
    .alu_op(alu_op), .alu_src(alu_src), .mem_2_reg(mem_2_reg),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump),
`ifdef CU_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .state_dbg(state_dbg), .cnt_dbg(cnt_dbg)
  );

  control_unit_pipe #(.MUL_LATENCY(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .arst_n(arst_n), .valid_in(valid_in1), .opcode(opcode1),
    .funct7(funct71), .flush(flush1), .stall(stall1), .valid_out(valid_out1),
    .alu_op(alu_op1), .alu_src(alu_src1), .mem_2_reg(mem_2_reg1),
    .reg_write(reg_write1), .mem_read(mem_read1), .mem_write(mem_write1),
    .branch(branch1), .jump(jump1),
`ifdef CU_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op1),
`endif
    .state_dbg(state_dbg1), .cnt_dbg(cnt_dbg1)
  );

  // Scoreboard counters and checker
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op,
                       input logic [6:0] f7, input logic fl);
    valid_in = v;
    opcode   = op;
    funct7   = f7;
    flush    = fl;
  endtask

  // Expected control words
  localparam logic [9:0] W_BUBBLE  = 10'b0_00_0000000;
  localparam logic [9:0] W_R       = 10'b1_10_0010000;
  localparam logic [9:0] W_I       = 10'b1_00_1010000;
  localparam logic [9:0] W_LOAD    = 10'b1_00_1111000;
  localparam logic [9:0] W_STORE   = 10'b1_00_1000100;
  localparam logic [9:0] W_BEQ     = 10'b1_01_0000010;
  localparam logic [9:0] W_JAL     = 10'b1_10_0000001;
  localparam logic [9:0] W_MUL_RUN = 10'b0_11_0000000;
  localparam logic [9:0] W_MUL_END = 10'b1_11_0010000;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  logic [6:0] sw_op  [8];
  logic [6:0] sw_f7  [8];
  logic [9:0] sw_exp [8];

  initial begin
    sw_op  = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0000011,
               7'b0100011, 7'b1100011, 7'b1101111, 7'b1111111};
    sw_f7  = '{7'b0000000, 7'b0100000, 7'b0000000, 7'b0000000,
               7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
    sw_exp = '{W_R, W_R, W_I, W_LOAD, W_STORE, W_BEQ, W_JAL, W_BUBBLE};

    // Reset
    arst_n = 1'b0;
    drive(1'b0, 7'd0, 7'd0, 1'b0);
    valid_in1 = 1'b0; opcode1 = 7'd0; funct71 = 7'd0; flush1 = 1'b0;
    step(); step();
    check("reset_word", 32'(word), 32'(W_BUBBLE));
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    arst_n = 1'b1;
    step();
    check("post_reset_word", 32'(word), 32'(W_BUBBLE));

    // Decode sweep
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, sw_op[i], sw_f7[i], 1'b0);
      step();
      check($sformatf("sweep%0d_word", i), 32'(word), 32'(sw_exp[i]));
      check($sformatf("sweep%0d_stall", i), 32'(stall), 32'd0);
`ifdef CU_ILLEGAL_TRAP_EN
      check($sformatf("sweep%0d_illegal", i), 32'(illegal_op),
            32'(sw_op[i] == 7'b1111111));
`endif
    end
    drive(1'b0, OP_I, 7'd0, 1'b0);
    step();
    check("no_valid_bubble", 32'(word), 32'(W_BUBBLE));
`ifdef CU_ILLEGAL_TRAP_EN
    check("illegal_one_cycle", 32'(illegal_op), 32'd0);
`endif

    // Multiply, latency 4, with an I instruction held behind it
    drive(1'b1, OP_R, F7_MUL, 1'b0);
    step();
    check("mul_e0_word", 32'(word), 32'(W_MUL_RUN));
    check("mul_e0_stall", 32'(stall), 32'd1);
    drive(1'b1, OP_I, 7'd0, 1'b0);
    step();
    check("mul_e1_word", 32'(word), 32'(W_MUL_RUN));
    check("mul_e1_stall", 32'(stall), 32'd1);
    step();
    check("mul_e2_word", 32'(word), 32'(W_MUL_RUN));
    check("mul_e2_stall", 32'(stall), 32'd1);
    step();
    check("mul_e3_word", 32'(word), 32'(W_MUL_END));
    check("mul_e3_stall", 32'(stall), 32'd0);
    step();
    check("mul_next_word", 32'(word), 32'(W_I));
    drive(1'b0, 7'd0, 7'd0, 1'b0);
    step();

    // Flush at cnt=2 aborts the multiply
    drive(1'b1, OP_R, F7_MUL, 1'b0);
    step();
    drive(1'b0, 7'd0, 7'd0, 1'b0);
    step();
    check("flush_cnt2", 32'(cnt_dbg), 32'd2);
    flush = 1'b1;
    #1;
    check("flush_stall_comb", 32'(stall), 32'd0);
    step();
    check("flush_word", 32'(word), 32'(W_BUBBLE));
    check("flush_state", 32'(state_dbg), 32'd0);
    flush = 1'b0;
    step(); step(); step();
    check("flush_no_rw", 32'(reg_write), 32'd0);
    check("flush_no_stall", 32'(stall), 32'd0);

    // Flush together with a valid BEQ, then with a valid MUL in IDLE
    drive(1'b1, OP_BEQ, 7'd0, 1'b1);
    step();
    check("flush_beq_word", 32'(word), 32'(W_BUBBLE));
    drive(1'b1, OP_R, F7_MUL, 1'b1);
    step();
    check("flush_mul_word", 32'(word), 32'(W_BUBBLE));
    drive(1'b0, 7'd0, 7'd0, 1'b0);
    #1;
    check("flush_mul_stall", 32'(stall), 32'd0);

    // Asynchronous reset mid-multiply
    drive(1'b1, OP_R, F7_MUL, 1'b0);
    step();
    drive(1'b0, 7'd0, 7'd0, 1'b0);
    check("areset_pre_word", 32'(word), 32'(W_MUL_RUN));
    #2;
    arst_n = 1'b0;
    #1;
    check("areset_word", 32'(word), 32'(W_BUBBLE));
    check("areset_stall", 32'(stall), 32'd0);
    check("areset_cnt", 32'(cnt_dbg), 32'd0);
    #1;
    arst_n = 1'b1;
    step(); step(); step(); step();
    check("areset_no_rw", 32'(reg_write), 32'd0);

    // MUL_LATENCY = 1: behaves like an R-type with alu_op 11
    valid_in1 = 1'b1; opcode1 = OP_R; funct71 = F7_MUL;
    #1;
    check("lat1_stall_comb", 32'(stall1), 32'd0);
    step();
    check("lat1_mul_word", 32'(word1), 32'(W_MUL_END));
    check("lat1_stall", 32'(stall1), 32'd0);
    opcode1 = OP_I; funct71 = 7'd0;
    step();
    check("lat1_next_word", 32'(word1), 32'(W_I));
    valid_in1 = 1'b0;
    step();
    check("lat1_bubble", 32'(word1), 32'(W_BUBBLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
